count_sequencer: RTL and testbench

- Control stage that sits directly upstream of the 6-bit rollover counter (counter_64) and drives its count_enable, clear and rollover_val inputs.
- Runs a programmable burst: clears the counter, then issues prescaled count_enable pulses until the counter has rolled over a programmed number of times, then reports completion.
- Watches the counter's rollover_flag to know when each rollover has happened.

---
 rtl/count_sequencer_if.sv | 29 ++
 rtl/count_sequencer.sv | 104 ++++++++++
 tb/tb_count_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_if.sv
// Control/status bundle between the burst sequencer and its surroundings:
// burst request inputs, the downstream counter's rollover flag, and the counter drive outputs.
interface count_sequencer_if #(
    parameter int PRESCALE_BITS = 4,
    parameter int NUM_CNT_BITS  = 6,
    parameter int BURST_BITS    = 4
);
    logic                     start_i;
    logic                     abort_i;
    logic [PRESCALE_BITS-1:0] prescale_i;
    logic [NUM_CNT_BITS-1:0]  period_i;
    logic [BURST_BITS-1:0]    num_bursts_i;
    logic                     rollover_flag_i;
    logic                     count_enable_o;
    logic                     clear_o;
    logic [NUM_CNT_BITS-1:0]  rollover_val_o;
    logic                     busy_o;
    logic                     done_o;

    modport master (
        output start_i, abort_i, prescale_i, period_i, num_bursts_i, rollover_flag_i,
        input  count_enable_o, clear_o, rollover_val_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, prescale_i, period_i, num_bursts_i, rollover_flag_i,
        output count_enable_o, clear_o, rollover_val_o, busy_o, done_o
    );
endinterface

// File: rtl/count_sequencer.sv
// Burst sequencer for a rollover counter: clears it, issues prescaled enables
// until the programmed number of rollovers is seen, then pulses done.
module count_sequencer #(
    parameter int PRESCALE_BITS = 4,
    parameter int NUM_CNT_BITS  = 6,
    parameter int BURST_BITS    = 4
) (
    input  logic               clk,
    input  logic               rst,
    count_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_e;

    state_e                   state_q, state_d;
    logic [PRESCALE_BITS-1:0] prescale_q, prescale_d;
    logic [PRESCALE_BITS-1:0] div_q, div_d;
    logic [NUM_CNT_BITS-1:0]  period_q, period_d;
    logic [BURST_BITS-1:0]    bursts_q, bursts_d;
    logic [BURST_BITS-1:0]    tally_q, tally_d;
    logic [BURST_BITS-1:0]    tally_inc;
    logic                     flag_q, flag_d;
    logic                     accept, tick, rise, last_roll;

    always_comb begin
        accept    = (state_q == S_IDLE) && bus.start_i && (bus.period_i != '0);
        tick      = (div_q == prescale_q);
        rise      = bus.rollover_flag_i & ~flag_q;
        tally_inc = tally_q + 1'b1;
        // tally cannot wrap: the rollover that reaches the target leaves RUN
        last_roll = rise && (tally_inc == bursts_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (bus.num_bursts_i != '0) ? S_CLEAR : S_DONE;
            S_CLEAR: state_d = bus.abort_i ? S_IDLE : S_RUN;
            S_RUN: begin
                if (bus.abort_i)      state_d = S_IDLE;
                else if (last_roll)   state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.count_enable_o = (state_q == S_RUN) && tick && !last_roll && !bus.abort_i;
        bus.clear_o        = (state_q == S_CLEAR);
        bus.busy_o         = (state_q == S_CLEAR) || (state_q == S_RUN);
        bus.done_o         = (state_q == S_DONE);
        bus.rollover_val_o = period_q;
    end

    always_comb begin
        prescale_d = prescale_q;
        period_d   = period_q;
        bursts_d   = bursts_q;
        div_d      = div_q;
        tally_d    = tally_q;
        flag_d     = flag_q;
        if (accept) begin
            prescale_d = bus.prescale_i;
            period_d   = bus.period_i;
            bursts_d   = bus.num_bursts_i;
        end
        case (state_q)
            S_CLEAR: begin
                div_d   = '0;
                tally_d = '0;
                flag_d  = 1'b0;
            end
            S_RUN: begin
                div_d  = tick ? '0 : div_q + 1'b1;
                flag_d = bus.rollover_flag_i;
                if (rise) tally_d = tally_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            period_q   <= '0;
            bursts_q   <= '0;
            div_q      <= '0;
            tally_q    <= '0;
            flag_q     <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            period_q   <= period_d;
            bursts_q   <= bursts_d;
            div_q      <= div_d;
            tally_q    <= tally_d;
            flag_q     <= flag_d;
        end
    end
endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a behavioural rollover counter attached
// and a cycle-indexed burst model checked every cycle.
module tb_count_sequencer;
    localparam int PB = 4;
    localparam int NB = 6;
    localparam int BB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    count_sequencer_if #(.PRESCALE_BITS(PB), .NUM_CNT_BITS(NB), .BURST_BITS(BB)) bus();

    count_sequencer #(.PRESCALE_BITS(PB), .NUM_CNT_BITS(NB), .BURST_BITS(BB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream counter: sync clear, enable, rolls over to 1 after reaching rollover_val
    logic [NB-1:0] cnt_q;
    always @(posedge clk or posedge rst) begin
        if (rst)                     cnt_q <= '0;
        else if (bus.clear_o)        cnt_q <= '0;
        else if (bus.count_enable_o) cnt_q <= (cnt_q == bus.rollover_val_o) ? NB'(1) : cnt_q + 1'b1;
    end
    assign bus.rollover_flag_i = (cnt_q == bus.rollover_val_o);

    // Model: m_c = cycles since accepted start (0 = clear cycle), -1 idle, -2 immediate done.
    // Burst of N rollovers with period P needs N*P enables, one every p+1 cycles.
    int            m_c = -1;
    int            m_F = 0;
    int            m_p = 0;
    logic [NB-1:0] m_rv = '0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_c  <= -1;
            m_rv <= '0;
        end else if (m_c == -1) begin
            if (bus.start_i && bus.period_i != '0) begin
                m_rv <= bus.period_i;
                m_p  <= int'(bus.prescale_i);
                m_F  <= int'(bus.num_bursts_i) * int'(bus.period_i) * (int'(bus.prescale_i) + 1);
                m_c  <= (bus.num_bursts_i == '0) ? -2 : 0;
            end
        end else if (m_c == -2) begin
            m_c <= -1;
        end else if (bus.abort_i && m_c <= m_F + 1) begin
            m_c <= -1;
        end else if (m_c >= m_F + 2) begin
            m_c <= -1;
        end else begin
            m_c <= m_c + 1;
        end
    end

    int n_ce, n_clr, n_done, n_busy, n_gap, last_ce, busy_at_done;
    int gaps [8];

    always @(negedge clk) begin
        if (!rst) begin
            logic e_ce, e_clr, e_busy, e_done;
            e_clr  = (m_c == 0);
            e_busy = (m_c >= 0) && (m_c <= m_F + 1);
            e_done = (m_c == -2) || (m_c == m_F + 2);
            e_ce   = (m_c >= 1) && (m_c <= m_F) && (m_c % (m_p + 1) == 0) && !bus.abort_i;
            chk("count_enable", 32'(bus.count_enable_o), 32'(e_ce));
            chk("clear", 32'(bus.clear_o), 32'(e_clr));
            chk("busy", 32'(bus.busy_o), 32'(e_busy));
            chk("done", 32'(bus.done_o), 32'(e_done));
            chk("rollover_val", 32'(bus.rollover_val_o), 32'(m_rv));
            if (bus.count_enable_o) begin
                if (last_ce >= 0 && n_gap < 8) begin
                    gaps[n_gap] = cyc - last_ce;
                    n_gap++;
                end
                last_ce = cyc;
                n_ce++;
            end
            if (bus.clear_o) n_clr++;
            if (bus.busy_o)  n_busy++;
            if (bus.done_o) begin
                n_done++;
                busy_at_done = int'(bus.busy_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic clr_stats();
        n_ce = 0; n_clr = 0; n_done = 0; n_busy = 0; n_gap = 0; last_ce = -1; busy_at_done = -1;
    endtask

    task automatic do_start(input int p, input int per, input int nb);
        bus.prescale_i   = PB'(p);
        bus.period_i     = NB'(per);
        bus.num_bursts_i = BB'(nb);
        bus.start_i      = 1'b1;
        step();
        bus.start_i      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int k;
        k = 0;
        while (n_done == 0 && k < maxc) begin
            step();
            k++;
        end
        if (n_done == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_ce"},   32'(bus.count_enable_o), 32'd0);
        chk({name, "_clr"},  32'(bus.clear_o), 32'd0);
        chk({name, "_busy"}, 32'(bus.busy_o), 32'd0);
        chk({name, "_done"}, 32'(bus.done_o), 32'd0);
        chk({name, "_rv"},   32'(bus.rollover_val_o), 32'd0);
    endtask

    initial begin
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        bus.prescale_i = '0; bus.period_i = '0; bus.num_bursts_i = '0;
        clr_stats();
        #12;
        chk_outputs_zero("reset");
        step();
        rst = 1'b0;
        step();

        // two rollovers of period 4, enable every cycle
        clr_stats();
        do_start(0, 4, 2);
        wait_done("burst_4x2", 100);
        chk("burst_4x2_pulses", n_ce, 8);
        chk("burst_4x2_clears", n_clr, 1);
        chk("burst_4x2_count", 32'(cnt_q), 4);
        repeat (5) step();
        chk("burst_4x2_count_hold", 32'(cnt_q), 4);
        chk("burst_4x2_done_once", n_done, 1);

        // prescaled single rollover
        clr_stats();
        do_start(3, 3, 1);
        wait_done("prescale3", 100);
        chk("prescale3_pulses", n_ce, 3);
        chk("prescale3_gap0", gaps[0], 4);
        chk("prescale3_gap1", gaps[1], 4);
        chk("prescale3_busy_at_done", busy_at_done, 0);

        // abort in RUN on a cycle where an enable would have fired
        clr_stats();
        do_start(1, 10, 3);
        step();
        step();
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        chk("abort_busy_next", 32'(bus.busy_o), 0);
        repeat (10) step();
        chk("abort_no_done", n_done, 0);
        chk("abort_no_pulses", n_ce, 0);
        chk("abort_rv_kept", 32'(bus.rollover_val_o), 10);
        clr_stats();
        do_start(0, 2, 1);
        wait_done("after_abort", 50);
        chk("after_abort_pulses", n_ce, 2);

        // zero bursts: immediate done
        clr_stats();
        do_start(2, 5, 0);
        repeat (3) step();
        chk("zero_bursts_done", n_done, 1);
        chk("zero_bursts_clear", n_clr, 0);
        chk("zero_bursts_ce", n_ce, 0);
        chk("zero_bursts_rv", 32'(bus.rollover_val_o), 5);

        // zero period: ignored entirely
        clr_stats();
        do_start(0, 0, 3);
        repeat (5) step();
        chk("zero_period_done", n_done, 0);
        chk("zero_period_busy", n_busy, 0);
        chk("zero_period_rv", 32'(bus.rollover_val_o), 5);

        // start during RUN is ignored
        clr_stats();
        do_start(1, 6, 2);
        repeat (5) step();
        do_start(0, 9, 1);
        chk("restart_rv", 32'(bus.rollover_val_o), 6);
        wait_done("restart", 200);
        chk("restart_pulses", n_ce, 12);
        chk("restart_done_once", n_done, 1);
        chk("restart_rv_end", 32'(bus.rollover_val_o), 6);

        // asynchronous reset in the middle of a burst
        clr_stats();
        do_start(0, 5, 3);
        repeat (6) step();
        chk("pre_reset_ce", 32'(bus.count_enable_o), 1);
        #1 rst = 1'b1;
        #1;
        chk_outputs_zero("midrun_reset");
        step();
        rst = 1'b0;
        step();
        clr_stats();
        do_start(0, 2, 1);
        wait_done("post_reset", 50);
        chk("post_reset_pulses", n_ce, 2);

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end
endmodule
